// File: rtl/lamp_sqrt_arbiter_pkg.sv
// Shared types and constants for the sqrt arbiter slice: significand/result
// widths derived from the float fraction width, and the arbiter FSM encoding.
package lamp_sqrt_arbiter_pkg;

    localparam int LAMP_FLOAT_F_DW = 7;

    localparam int SIG_W = LAMP_FLOAT_F_DW + 1;
    localparam int RES_W = 2 * (LAMP_FLOAT_F_DW + 1);

    typedef logic [LAMP_FLOAT_F_DW:0]     lamp_sig_t;
    typedef logic [2*LAMP_FLOAT_F_DW+1:0] lamp_sqrt_res_t;

    // Fixed state codes so existing debug tooling keeps decoding the same values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } sqrt_arb_state_t;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
    function automatic int wdog_width(input int timeout_cyc);
        int w;
        w = (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lamp_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// above the pointer, wrapping modulo N_REQ, as both one-hot and index.
module lamp_rr_picker #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_WIDE = (IDX_W+1)'(N_REQ);

    // cand_idx[gi] is the requester sitting gi places above the pointer.
    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum           = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= N_WIDE) ? IDX_W'(sum - N_WIDE) : sum[IDX_W-1:0];
            assign cand_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the closest requester wins.
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        onehot = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                idx = cand_idx[i];
                any = 1'b1;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lamp_sqrt_arbiter.sv
// Shares one iterative significand sqrt unit between N_REQ FPU lanes.
// One transaction in flight, round-robin grant, watchdog error response.
module lamp_sqrt_arbiter
    import lamp_sqrt_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*SIG_W-1:0] req_sig_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    input  logic [N_REQ-1:0]       rsp_ready_i,
    output logic [RES_W-1:0]       rsp_res_o,
    output logic                   rsp_err_o,
    output logic                   sqrt_do_o,
    output logic [SIG_W-1:0]       sqrt_sig_o,
    input  logic                   sqrt_valid_i,
    input  logic [RES_W-1:0]       sqrt_res_i,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = wdog_width(TIMEOUT_CYC);
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(N_REQ - 1);

    sqrt_arb_state_t  state_reg;
    logic [IDX_W-1:0] grant_reg;
    logic [IDX_W-1:0] rr_reg;
    logic [WD_W-1:0]  wdog_reg;
    lamp_sig_t        sig_reg;
    lamp_sqrt_res_t   res_reg;
    logic             err_reg;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // Per-requester view of the packed significand bus.
    lamp_sig_t sig_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_sig
            assign sig_arr[gi] = req_sig_i[gi*SIG_W +: SIG_W];
        end
    endgenerate

    lamp_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req_valid_i),
        .ptr    (rr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Transaction FSM: accept, pulse the unit, wait with watchdog, hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            rr_reg    <= '0;
            wdog_reg  <= '0;
            sig_reg   <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        grant_reg <= pick_idx;
                        sig_reg   <= sig_arr[pick_idx];
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_reg  <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    // A real result beats a timeout landing on the same cycle.
                    if (sqrt_valid_i) begin
                        res_reg   <= sqrt_res_i;
                        err_reg   <= 1'b0;
                        state_reg <= RESP;
                    end else if (WD_EN && (wdog_reg == WD_LAST)) begin
                        res_reg   <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[grant_reg]) begin
                        rr_reg    <= (grant_reg == LAST_REQ) ? '0 : grant_reg + 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Response valid is steered to the granted requester only while in RESP.
    always_comb begin
        rsp_valid_o = '0;
        if (state_reg == RESP) begin
            rsp_valid_o[grant_reg] = 1'b1;
        end
    end

    // Accept is combinational so a lane sees ready in the same cycle it requests.
    assign req_ready_o = ((state_reg == IDLE) && !rst) ? pick_onehot : '0;
    assign sqrt_do_o   = (state_reg == ISSUE);
    assign sqrt_sig_o  = sig_reg;
    assign rsp_res_o   = (state_reg == RESP) ? res_reg : '0;
    assign rsp_err_o   = (state_reg == RESP) && err_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_lamp_sqrt_arbiter.sv
// Bench for lamp_sqrt_arbiter: a latency-programmable sqrt unit model plus a
// queue-free reference for round-robin order and expected results.
module tb_lamp_sqrt_arbiter;
    import lamp_sqrt_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [N*SIG_W-1:0]   req_sig_i;
    logic [N-1:0]         rsp_valid_o;
    logic [N-1:0]         rsp_ready_i;
    logic [RES_W-1:0]     rsp_res_o;
    logic                 rsp_err_o;
    logic                 sqrt_do_o;
    logic [SIG_W-1:0]     sqrt_sig_o;
    logic                 sqrt_valid_i = 1'b0;
    logic [RES_W-1:0]     sqrt_res_i = '0;
    logic                 busy_o;

    int checks   = 0;
    int errors   = 0;
    int rr_model = 0;
    int unit_lat = 1;
    int unit_cnt = 0;
    logic [SIG_W-1:0] unit_sig = '0;

    always #5 clk = ~clk;

    lamp_sqrt_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_sig_i    (req_sig_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_res_o    (rsp_res_o),
        .rsp_err_o    (rsp_err_o),
        .sqrt_do_o    (sqrt_do_o),
        .sqrt_sig_o   (sqrt_sig_o),
        .sqrt_valid_i (sqrt_valid_i),
        .sqrt_res_i   (sqrt_res_i),
        .busy_o       (busy_o)
    );

    // Deterministic stand-in for the sqrt datapath result.
    function automatic logic [RES_W-1:0] unit_res(input logic [SIG_W-1:0] s);
        logic [SIG_W-1:0] lo;
        lo = SIG_W'(s * 8'd3 + 8'd1);
        return {s, lo};
    endfunction

    // First requesting index at or above ptr, wrapping; -1 if none.
    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0 && k < N) v[k] = 1'b1;
        return v;
    endfunction

    // Sqrt unit model: answers unit_lat cycles after the start pulse (0 = never).
    always @(negedge clk) begin
        sqrt_valid_i = 1'b0;
        sqrt_res_i   = RES_W'($urandom);
        if (unit_cnt > 0) begin
            unit_cnt = unit_cnt - 1;
            if (unit_cnt == 0) begin
                sqrt_valid_i = 1'b1;
                sqrt_res_i   = unit_res(unit_sig);
            end
        end
        if (sqrt_do_o === 1'b1) begin
            unit_sig = sqrt_sig_o;
            unit_cnt = unit_lat;
        end
    end

    task automatic test_reset();
        rst         = 1'b1;
        req_valid_i = '1;
        rsp_ready_i = '1;
        req_sig_i   = (N*SIG_W)'($urandom);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_sig_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b res=%h err=%b do=%b sig=%h busy=%b, all required 0",
                     req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_sig_o, busy_o);
        end
        @(negedge clk);
        req_valid_i = '0;
        rsp_ready_i = '0;
        rst         = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || rsp_valid_o !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b rsp_valid=%b, required 0/0", busy_o, rsp_valid_o);
        end
        rr_model = 0;
    endtask

    task automatic test_single();
        int g;
        unit_lat = 6;
        @(negedge clk);
        req_valid_i = 4'b0010;
        req_sig_i   = {8'h11, 8'h22, 8'h80, 8'h33};
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL single_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        @(negedge clk);
        req_valid_i = '0;
        #1;
        checks++;
        if (sqrt_do_o !== 1'b1 || sqrt_sig_o !== 8'h80) begin
            errors++;
            $display("FAIL single_issue: do=%b sig=%h required 1/80", sqrt_do_o, sqrt_sig_o);
        end
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            #1;
            if (c < 8) begin
                checks++;
                if (rsp_valid_o !== '0 || sqrt_do_o !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early: t0+%0d rsp_valid=%b do=%b required 0/0", c, rsp_valid_o, sqrt_do_o);
                end
            end
        end
        checks++;
        if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'b0 || rsp_res_o !== unit_res(8'h80)) begin
            errors++;
            $display("FAIL single_resp: valid=%b err=%b res=%h required %b/0/%h",
                     rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g), unit_res(8'h80));
        end
        rsp_ready_i = onehot(g);
        @(negedge clk);
        rsp_ready_i = '0;
        #1;
        rr_model = (g + 1) % N;
        checks++;
        if (rsp_valid_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_release: rsp_valid=%b busy=%b required 0/0", rsp_valid_o, busy_o);
        end
        $display("txn single: grant=%0d sig=80 res=%h err=%b", g, unit_res(8'h80), 1'b0);
    endtask

    task automatic test_round_robin();
        int g;
        int n;
        bit overlap;
        logic [SIG_W-1:0] s;
        rsp_ready_i = '1;
        for (int k = 0; k < N; k++) req_sig_i[k*SIG_W +: SIG_W] = SIG_W'($urandom);
        req_valid_i = '1;
        #1;
        for (int t = 0; t < 12; t++) begin
            unit_lat = $urandom_range(1, 7);
            n = 0;
            while (req_ready_o === '0 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
            g = ref_pick(req_valid_i, rr_model);
            checks++;
            if (req_ready_o !== onehot(g)) begin
                errors++;
                $display("FAIL rr_grant: txn %0d req_ready_o=%b required %b", t, req_ready_o, onehot(g));
            end
            s = req_sig_i[g*SIG_W +: SIG_W];
            @(negedge clk);
            req_sig_i[g*SIG_W +: SIG_W] = SIG_W'($urandom);
            #1;
            checks++;
            if (sqrt_do_o !== 1'b1 || sqrt_sig_o !== s) begin
                errors++;
                $display("FAIL rr_issue: txn %0d do=%b sig=%h required 1/%h", t, sqrt_do_o, sqrt_sig_o, s);
            end
            overlap = 1'b0;
            n = 0;
            while (rsp_valid_o === '0 && n < 40) begin
                if (req_ready_o !== '0) overlap = 1'b1;
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (overlap || rsp_valid_o !== onehot(g) || rsp_res_o !== unit_res(s) || rsp_err_o !== 1'b0) begin
                errors++;
                $display("FAIL rr_resp: txn %0d overlap=%b valid=%b res=%h err=%b required 0/%b/%h/0",
                         t, overlap, rsp_valid_o, rsp_res_o, rsp_err_o, onehot(g), unit_res(s));
            end
            $display("txn rr %0d: grant=%0d sig=%h lat=%0d res=%h", t, g, s, unit_lat, rsp_res_o);
            rr_model = (g + 1) % N;
            @(negedge clk);
            #1;
        end
        req_valid_i = '0;
        rsp_ready_i = '0;
        #1;
    endtask

    task automatic test_backpressure();
        int g;
        int n;
        logic [SIG_W-1:0] s;
        logic [N-1:0] others;
        unit_lat    = 3;
        rsp_ready_i = '0;
        for (int k = 0; k < N; k++) req_sig_i[k*SIG_W +: SIG_W] = SIG_W'($urandom);
        req_valid_i = ~onehot($urandom_range(0, N - 1));
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL bp_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        s      = req_sig_i[g*SIG_W +: SIG_W];
        others = req_valid_i & ~onehot(g);
        @(negedge clk);
        req_valid_i = others;
        #1;
        n = 0;
        while (rsp_valid_o === '0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid_o !== onehot(g) || rsp_res_o !== unit_res(s)) begin
            errors++;
            $display("FAIL bp_resp: valid=%b res=%h required %b/%h", rsp_valid_o, rsp_res_o, onehot(g), unit_res(s));
        end
        for (int c = 0; c < 10; c++) begin
            rsp_ready_i = ~onehot(g);
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid_o !== onehot(g) || rsp_res_o !== unit_res(s) || rsp_err_o !== 1'b0 || req_ready_o !== '0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b res=%h err=%b ready=%b required %b/%h/0/0",
                         c, rsp_valid_o, rsp_res_o, rsp_err_o, req_ready_o, onehot(g), unit_res(s));
            end
        end
        rsp_ready_i = onehot(g);
        @(negedge clk);
        rsp_ready_i = '0;
        #1;
        rr_model = (g + 1) % N;
        checks++;
        if (rsp_valid_o !== '0) begin
            errors++;
            $display("FAIL bp_release: rsp_valid=%b required 0", rsp_valid_o);
        end
        checks++;
        if (req_ready_o !== onehot(ref_pick(others, rr_model))) begin
            errors++;
            $display("FAIL bp_next: req_ready_o=%b required %b", req_ready_o, onehot(ref_pick(others, rr_model)));
        end
        req_valid_i = '0;
        #1;
        $display("txn backpressure: grant=%0d sig=%h res=%h", g, s, unit_res(s));
    endtask

    task automatic test_timeout();
        int g;
        int k;
        int n;
        logic [SIG_W-1:0] s;
        unit_lat    = 0;
        rsp_ready_i = '0;
        k           = $urandom_range(0, N - 1);
        s           = SIG_W'($urandom);
        req_sig_i[k*SIG_W +: SIG_W] = s;
        req_valid_i = onehot(k);
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL to_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        @(negedge clk);
        req_valid_i = '0;
        #1;
        for (int c = 2; c <= TO + 2; c++) begin
            @(negedge clk);
            #1;
            if (c < TO + 2) begin
                checks++;
                if (rsp_valid_o !== '0 || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL to_early: t0+%0d rsp_valid=%b busy=%b required 0/1", c, rsp_valid_o, busy_o);
                end
            end
        end
        checks++;
        if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'b1 || rsp_res_o !== '0) begin
            errors++;
            $display("FAIL to_resp: valid=%b err=%b res=%h required %b/1/0", rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g));
        end
        $display("txn timeout: grant=%0d err=%b", g, rsp_err_o);
        rsp_ready_i = onehot(g);
        @(negedge clk);
        rsp_ready_i = '0;
        rr_model    = (g + 1) % N;
        // A normal request right after the error must be served as usual.
        unit_lat = 4;
        k        = $urandom_range(0, N - 1);
        s        = SIG_W'($urandom);
        req_sig_i[k*SIG_W +: SIG_W] = s;
        req_valid_i = onehot(k);
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL to_next_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        @(negedge clk);
        req_valid_i = '0;
        #1;
        n = 0;
        while (rsp_valid_o === '0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'b0 || rsp_res_o !== unit_res(s)) begin
            errors++;
            $display("FAIL to_next_resp: valid=%b err=%b res=%h required %b/0/%h",
                     rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g), unit_res(s));
        end
        rsp_ready_i = onehot(g);
        @(negedge clk);
        rsp_ready_i = '0;
        rr_model    = (g + 1) % N;
        #1;
        $display("txn after_timeout: grant=%0d sig=%h res=%h", g, s, unit_res(s));
    endtask

    task automatic test_valid_on_timeout();
        int g;
        int k;
        logic [SIG_W-1:0] s;
        logic [RES_W-1:0] exp_res;
        // Latency TO lands on the last watchdog cycle; TO+1 arrives one cycle too late.
        for (int r = 0; r < 2; r++) begin
            unit_lat = TO + r;
            k        = $urandom_range(0, N - 1);
            s        = SIG_W'($urandom);
            req_sig_i[k*SIG_W +: SIG_W] = s;
            req_valid_i = onehot(k);
            #1;
            g = ref_pick(req_valid_i, rr_model);
            checks++;
            if (req_ready_o !== onehot(g)) begin
                errors++;
                $display("FAIL vt_accept: lat=%0d req_ready_o=%b required %b", unit_lat, req_ready_o, onehot(g));
            end
            exp_res = (r == 0) ? unit_res(s) : '0;
            @(negedge clk);
            req_valid_i = '0;
            #1;
            repeat (TO + 1) @(negedge clk);
            #1;
            checks++;
            if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'(r) || rsp_res_o !== exp_res) begin
                errors++;
                $display("FAIL vt_resp: lat=%0d valid=%b err=%b res=%h required %b/%0d/%h",
                         unit_lat, rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g), r, exp_res);
            end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'(r) || rsp_res_o !== exp_res) begin
                errors++;
                $display("FAIL vt_hold: lat=%0d valid=%b err=%b res=%h required %b/%0d/%h",
                         unit_lat, rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g), r, exp_res);
            end
            $display("txn valid_on_timeout: lat=%0d grant=%0d err=%b res=%h", unit_lat, g, rsp_err_o, rsp_res_o);
            rsp_ready_i = onehot(g);
            @(negedge clk);
            rsp_ready_i = '0;
            rr_model    = (g + 1) % N;
        end
        #1;
    endtask

    task automatic test_reset_in_wait();
        int g;
        int k;
        int n;
        logic [SIG_W-1:0] s;
        // Serve requester 0 first so the pointer is away from 0 before the reset.
        unit_lat    = 2;
        rsp_ready_i = '1;
        req_valid_i = 4'b0001;
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL rw_pre_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        @(negedge clk);
        req_valid_i = '0;
        #1;
        n = 0;
        while (rsp_valid_o === '0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        rsp_ready_i = '0;
        rr_model    = (g + 1) % N;
        // Transaction that gets aborted while waiting on the unit.
        unit_lat = 5;
        k        = $urandom_range(1, N - 1);
        req_sig_i[k*SIG_W +: SIG_W] = SIG_W'($urandom);
        req_valid_i = onehot(k);
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL rw_accept: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        @(negedge clk);
        req_valid_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        rr_model = 0;
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_sig_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL rw_outputs: ready=%b rsp_valid=%b res=%h err=%b do=%b sig=%h busy=%b, all required 0",
                     req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_sig_o, busy_o);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid_o !== '0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rw_stray: cycle %0d rsp_valid=%b busy=%b required 0/0", c, rsp_valid_o, busy_o);
            end
        end
        unit_lat = 3;
        for (int j = 0; j < N; j++) req_sig_i[j*SIG_W +: SIG_W] = SIG_W'($urandom);
        req_valid_i = '1;
        rsp_ready_i = '1;
        #1;
        g = ref_pick(req_valid_i, rr_model);
        checks++;
        if (req_ready_o !== onehot(g)) begin
            errors++;
            $display("FAIL rw_restart: req_ready_o=%b required %b", req_ready_o, onehot(g));
        end
        s = req_sig_i[g*SIG_W +: SIG_W];
        @(negedge clk);
        req_valid_i = '0;
        #1;
        n = 0;
        while (rsp_valid_o === '0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid_o !== onehot(g) || rsp_err_o !== 1'b0 || rsp_res_o !== unit_res(s)) begin
            errors++;
            $display("FAIL rw_resp: valid=%b err=%b res=%h required %b/0/%h",
                     rsp_valid_o, rsp_err_o, rsp_res_o, onehot(g), unit_res(s));
        end
        $display("txn after_reset: grant=%0d sig=%h res=%h", g, s, unit_res(s));
        @(negedge clk);
        rsp_ready_i = '0;
        rr_model    = (g + 1) % N;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_sig_i   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_valid_on_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bug wedges the bench.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
